// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART Tx FIFO write-port arbiter.
// The idle-lock timeout counter width is derived here; it is only used when UART_ARB_TIMEOUT_EN is defined.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    // Idle-lock counter is kept between 8 and 16 bits wide.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping at NUM_REQ.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART Tx FIFO write port.
// Optional idle-lock release is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        CLK,
    input  logic                        Areset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              accept;
    logic              timeout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
        $error("uart_tx_arbiter: parameter out of range");
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign owner_data  = req_data[int'(grant_q) * DATA_W +: DATA_W];
    // Reset gates the write path so an in-flight byte is never pushed while the lock is dropped.
    assign accept      = (state_q == LOCK) && owner_valid && !fifo_full && !Areset;
    assign next_ptr    = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] idle_cnt_q;
    logic             stall_idle;

    // Only owner-idle cycles count; cycles stalled by a full FIFO do not.
    assign stall_idle  = (state_q == LOCK) && !owner_valid && !fifo_full && !Areset;
    assign timeout_hit = stall_idle && (idle_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (Areset || (state_q == IDLE) || accept) begin
            idle_cnt_q <= '0;
        end else if (stall_idle) begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_pulse = timeout_hit;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Areset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (!Areset) begin
                    req_ready[grant_q] = !fifo_full;
                    fifo_wr_en         = accept;
                    fifo_wr_data       = owner_data;
                end
                if ((accept && owner_last) || timeout_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == LOCK);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes, TIMEOUT=10).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 10;

    logic                      CLK = 1'b0;
    logic                      Areset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      timeout_pulse;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .Areset        (Areset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-requester packet source: {last, data}
    logic [8:0]         srcq [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold;
    logic [NUM_REQ-1:0] acc;

    logic [7:0] wr_log [$];
    int         wr_cyc [$];
    logic [1:0] wr_gnt [$];

    int                 s_cyc;
    logic               s_wr_en;
    logic [7:0]         s_data;
    logic [NUM_REQ-1:0] s_ready;
    logic               s_busy;
    logic [1:0]         s_grant;
    logic               s_pulse;

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcq[i].size() > 0 && !hold[i]) begin
                h = srcq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*DATA_W +: DATA_W] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DATA_W +: DATA_W] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // One clock: snapshot outputs mid-cycle, then advance sources past the edge.
    task automatic step();
        @(negedge CLK);
        s_cyc   = cyc;
        s_wr_en = fifo_wr_en;
        s_data  = fifo_wr_data;
        s_ready = req_ready;
        s_busy  = busy;
        s_grant = grant_id;
        s_pulse = timeout_pulse;
        if (fifo_wr_en === 1'b1) begin
            wr_log.push_back(fifo_wr_data);
            wr_cyc.push_back(cyc);
            wr_gnt.push_back(grant_id);
        end
        acc = req_valid & req_ready;
        cyc++;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] === 1'b1 && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
        wr_gnt.delete();
    endtask

    task automatic test_reset();
        Areset    = 1'b1;
        fifo_full = 1'b0;
        hold      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        drive();
        step();
        step();
        checks++; if (s_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b expected 0", s_busy); end
        checks++; if (s_grant !== 2'd0)    begin errors++; $display("FAIL reset_grant got %0d expected 0", s_grant); end
        checks++; if (s_wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got %b expected 0", s_wr_en); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b expected 0000", s_ready); end
        checks++; if (s_data !== 8'h00)    begin errors++; $display("FAIL reset_wr_data got %h expected 00", s_data); end
        checks++; if (s_pulse !== 1'b0)    begin errors++; $display("FAIL reset_pulse got %b expected 0", s_pulse); end
        Areset = 1'b0;
        drive();
    endtask

    task automatic test_contention();
        int start;
        clear_log();
        for (int i = 0; i < NUM_REQ; i++) begin
            srcq[i].push_back({1'b1, 8'(8'hA0 + i)});
        end
        drive();
        start = cyc;
        for (int k = 0; k < 40 && wr_log.size() < 4; k++) step();
        checks++;
        if (wr_log.size() != 4) begin
            errors++; $display("FAIL contention_count got %0d expected 4", wr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (wr_log[k] !== 8'(8'hA0 + k)) begin errors++; $display("FAIL contention_data[%0d] got %h expected %h", k, wr_log[k], 8'(8'hA0 + k)); end
                checks++; if (wr_gnt[k] !== 2'(k))          begin errors++; $display("FAIL contention_grant[%0d] got %0d expected %0d", k, wr_gnt[k], k); end
            end
            for (int k = 0; k < 3; k++) begin
                checks++; if (wr_cyc[k+1] - wr_cyc[k] != 2) begin errors++; $display("FAIL contention_gap[%0d] got %0d expected 2", k, wr_cyc[k+1] - wr_cyc[k]); end
            end
            checks++; if (wr_cyc[0] - start != 1) begin errors++; $display("FAIL contention_latency got %0d expected 1", wr_cyc[0] - start); end
        end
    endtask

    task automatic test_packet_lock();
        int s;
        logic [7:0] exp_d [4];
        int         exp_c [4];
        logic [1:0] exp_g [4];
        clear_log();
        srcq[0].push_back({1'b1, 8'h5A});
        drive();
        for (int k = 0; k < 20 && wr_log.size() < 1; k++) step();
        checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL lock_preface got %0d writes expected 1", wr_log.size()); end
        clear_log();
        srcq[1].push_back({1'b0, 8'h11});
        srcq[1].push_back({1'b0, 8'h12});
        srcq[1].push_back({1'b1, 8'h13});
        srcq[0].push_back({1'b1, 8'h01});
        drive();
        s = cyc;
        exp_d = '{8'h11, 8'h12, 8'h13, 8'h01};
        exp_c = '{s + 1, s + 2, s + 3, s + 5};
        exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
        for (int k = 0; k < 40 && wr_log.size() < 4; k++) step();
        checks++;
        if (wr_log.size() != 4) begin
            errors++; $display("FAIL lock_count got %0d expected 4", wr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (wr_log[k] !== exp_d[k]) begin errors++; $display("FAIL lock_data[%0d] got %h expected %h", k, wr_log[k], exp_d[k]); end
                checks++; if (wr_cyc[k] != exp_c[k])  begin errors++; $display("FAIL lock_cycle[%0d] got %0d expected %0d", k, wr_cyc[k], exp_c[k]); end
                checks++; if (wr_gnt[k] !== exp_g[k]) begin errors++; $display("FAIL lock_grant[%0d] got %0d expected %0d", k, wr_gnt[k], exp_g[k]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        clear_log();
        srcq[0].push_back({1'b0, 8'h21});
        srcq[0].push_back({1'b0, 8'h22});
        srcq[0].push_back({1'b1, 8'h23});
        drive();
        for (int k = 0; k < 20 && wr_log.size() < 1; k++) step();
        fifo_full = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (s_wr_en !== 1'b0)    begin errors++; $display("FAIL bp_wr_en[%0d] got %b expected 0", k, s_wr_en); end
            checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b expected 0000", k, s_ready); end
            checks++; if (s_busy !== 1'b1)     begin errors++; $display("FAIL bp_busy[%0d] got %b expected 1", k, s_busy); end
        end
        fifo_full = 1'b0;
        drive();
        step();
        checks++; if (s_wr_en !== 1'b1) begin errors++; $display("FAIL bp_resume_wr_en got %b expected 1", s_wr_en); end
        checks++; if (s_data !== 8'h22) begin errors++; $display("FAIL bp_resume_data got %h expected 22", s_data); end
        for (int k = 0; k < 20 && wr_log.size() < 3; k++) step();
        step();
        checks++;
        if (wr_log.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d expected 3", wr_log.size());
        end else begin
            checks++; if (wr_log[0] !== 8'h21 || wr_log[1] !== 8'h22 || wr_log[2] !== 8'h23) begin
                errors++; $display("FAIL bp_sequence got %h %h %h expected 21 22 23", wr_log[0], wr_log[1], wr_log[2]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_log();
        srcq[1].push_back({1'b0, 8'h31});
        srcq[1].push_back({1'b0, 8'h32});
        srcq[1].push_back({1'b0, 8'h33});
        srcq[1].push_back({1'b1, 8'h34});
        drive();
        for (int k = 0; k < 20 && wr_log.size() < 2; k++) step();
        Areset = 1'b1;
        drive();
        step();
        checks++; if (s_wr_en !== 1'b0)    begin errors++; $display("FAIL rst_mid_wr_en got %b expected 0", s_wr_en); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got %b expected 0000", s_ready); end
        Areset = 1'b0;
        srcq[1].delete();
        srcq[0].push_back({1'b1, 8'h40});
        srcq[2].push_back({1'b1, 8'h42});
        drive();
        step();
        checks++; if (s_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got %b expected 0", s_busy); end
        checks++; if (s_grant !== 2'd0) begin errors++; $display("FAIL rst_mid_grant got %0d expected 0", s_grant); end
        checks++; if (s_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_idle_wr got %b expected 0", s_wr_en); end
        for (int k = 0; k < 20 && wr_log.size() < 4; k++) step();
        step();
        checks++;
        if (wr_log.size() != 4) begin
            errors++; $display("FAIL rst_mid_count got %0d expected 4", wr_log.size());
        end else begin
            checks++; if (wr_log[2] !== 8'h40) begin errors++; $display("FAIL rst_mid_first got %h expected 40", wr_log[2]); end
            checks++; if (wr_gnt[2] !== 2'd0)  begin errors++; $display("FAIL rst_mid_first_grant got %0d expected 0", wr_gnt[2]); end
            checks++; if (wr_log[3] !== 8'h42) begin errors++; $display("FAIL rst_mid_second got %h expected 42", wr_log[3]); end
        end
    endtask

    task automatic test_timeout();
        int w;
        clear_log();
        srcq[3].push_back({1'b0, 8'h51});
        srcq[3].push_back({1'b1, 8'h52});
        drive();
        for (int k = 0; k < 20 && wr_log.size() < 1; k++) step();
        w = (wr_cyc.size() > 0) ? wr_cyc[0] : 0;
        hold[3] = 1'b1;
        srcq[2].push_back({1'b1, 8'h61});
        drive();
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int   pulse_cnt = 0;
            int   pulse_cyc = -1;
            logic b11 = 1'bx;
            logic b12 = 1'bx;
            logic [1:0] g12 = 2'bxx;
            for (int k = 0; k < 20; k++) begin
                step();
                if (s_pulse === 1'b1) begin
                    pulse_cnt++;
                    if (pulse_cyc < 0) pulse_cyc = s_cyc;
                end
                if (s_cyc == w + 11) b11 = s_busy;
                if (s_cyc == w + 12) begin b12 = s_busy; g12 = s_grant; end
            end
            checks++; if (pulse_cyc != w + 10) begin errors++; $display("FAIL to_pulse_cycle got %0d expected %0d", pulse_cyc, w + 10); end
            checks++; if (pulse_cnt != 1)      begin errors++; $display("FAIL to_pulse_width got %0d expected 1", pulse_cnt); end
            checks++; if (b11 !== 1'b0)        begin errors++; $display("FAIL to_release_busy got %b expected 0", b11); end
            checks++; if (b12 !== 1'b1)        begin errors++; $display("FAIL to_regrant_busy got %b expected 1", b12); end
            checks++; if (g12 !== 2'd2)        begin errors++; $display("FAIL to_regrant_id got %0d expected 2", g12); end
            checks++;
            if (wr_log.size() != 2) begin
                errors++; $display("FAIL to_write_count got %0d expected 2", wr_log.size());
            end else begin
                checks++; if (wr_log[1] !== 8'h61 || wr_cyc[1] != w + 12) begin
                    errors++; $display("FAIL to_req2_write got %h@%0d expected 61@%0d", wr_log[1], wr_cyc[1], w + 12);
                end
            end
            hold[3] = 1'b0;
            drive();
            for (int k = 0; k < 20 && wr_log.size() < 3; k++) step();
            checks++; if (wr_log.size() != 3 || wr_log[wr_log.size()-1] !== 8'h52) begin
                errors++; $display("FAIL to_resume got %0d writes expected 3 ending in 52", wr_log.size());
            end
        end
`else
        begin
            int bad = 0;
            for (int k = 0; k < 1000; k++) begin
                step();
                if (s_busy !== 1'b1 || s_grant !== 2'd3 || s_wr_en !== 1'b0 || s_pulse !== 1'b0) bad++;
            end
            checks++; if (bad != 0)            begin errors++; $display("FAIL lock_persist bad cycles got %0d expected 0", bad); end
            checks++; if (wr_log.size() != 1)  begin errors++; $display("FAIL lock_persist writes got %0d expected 1", wr_log.size()); end
            hold[3] = 1'b0;
            drive();
            for (int k = 0; k < 20 && wr_log.size() < 3; k++) step();
            checks++;
            if (wr_log.size() != 3) begin
                errors++; $display("FAIL lock_resume_count got %0d expected 3", wr_log.size());
            end else begin
                checks++; if (wr_log[1] !== 8'h52 || wr_log[2] !== 8'h61) begin
                    errors++; $display("FAIL lock_resume_order got %h %h expected 52 61", wr_log[1], wr_log[2]);
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_contention();
        test_packet_lock();
        test_back_pressure();
        test_reset_mid_packet();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Packet-locked round-robin arbiter that shares the single UART transmit FIFO write port among `NUM_REQ` byte producers.
- It sits between the requesters and the Tx FIFO's write side: `FIFO_Tx_Input` / `Write_Enable` / `FIFO_Tx_Full`.
- A granted requester holds the FIFO until its `last` byte is written, so multi-byte messages never interleave on the serial line.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width; must match the Tx FIFO.
- `TIMEOUT`, 255: idle-lock limit in cycles; used only with `UART_ARB_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  system clock; all state updates on rising edge.
- `Areset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  byte is the final one of its packet.
- `req_ready`  out  NUM_REQ  byte accepted this cycle when ANDed with `req_valid`.
- `fifo_full`  in  1  Tx FIFO full flag.
- `fifo_wr_en`  out  1  Tx FIFO write strobe.
- `fifo_wr_data`  out  DATA_W  Tx FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  current or last owner.
- `busy`  out  1  high while a packet lock is held.
- `timeout_pulse`  out  1  one-cycle pulse on forced lock release.

## Operation

- States are IDLE and LOCK.
- **IDLE:**
  - If any `req_valid` is set, pick the first set bit searching upward from `rr_ptr`, wrapping at `NUM_REQ`.
  - Register that index into `grant_id`, then go to LOCK.
  - If no request is valid, stay in IDLE.
- **LOCK (owner g = `grant_id`):**
  - `req_ready[g] = ~fifo_full`; every other `req_ready` bit is 0.
  - `fifo_wr_en = req_valid[g] & ~fifo_full`.
  - `fifo_wr_data = req_data[g]`.
  - On an accepted byte with `req_last[g]`: go to IDLE and set `rr_ptr = (g+1) mod NUM_REQ`.
- Back-pressure: while `fifo_full` is high, nothing is written and the lock is held. No byte is ever dropped or duplicated.
- Owner drops `req_valid` mid-packet: the lock is held and no other requester is served.
- A single-byte packet (`req_valid` and `req_last` together) gets one write, then the lock is released.
- Reset mid-packet:
  - Lock is abandoned immediately; the FIFO contents are not touched.
  - A requester must restart its packet after reset.
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant_id` 0, `busy` 0, `timeout_pulse` 0.
  - All `req_ready` 0, `fifo_wr_en` 0, `fifo_wr_data` 0.

## Timing

- Arbitration takes 1 cycle: a request seen in IDLE at edge n is writable from cycle n+1.
- Write path is combinational from `req_valid[g]`/`fifo_full` to `fifo_wr_en`/`req_ready`. There is no registered stage, so the FIFO cannot overflow.
- Sustained throughput is 1 byte/cycle within a packet.
- Each packet boundary costs exactly 1 IDLE cycle.
- `busy` equals (state == LOCK), driven from the state register.
- Requester contract: `req_data` and `req_last` stay stable while `req_valid` is high and `req_ready` is low.

## Configuration

- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8..16-bit counter clears on every accepted byte and on entry to LOCK.
  - It increments each LOCK cycle with `req_valid[g]==0` and `fifo_full==0`; cycles stalled by a full FIFO are never counted.
  - When the count reaches `TIMEOUT`: go to IDLE, set `rr_ptr = g+1`, and pulse `timeout_pulse` for one cycle.
- **Not defined:** no counter exists, `timeout_pulse` is tied to 0, and a lock is held indefinitely.

## Structure

- Package `uart_arb_pkg` holds:
  - the state enum (IDLE, LOCK);
  - the default `NUM_REQ` and `DATA_W` constants;
  - the default `TIMEOUT` constant.
- Sub-module `uart_rr_picker`: combinational; takes the valid vector and `rr_ptr`, returns a found flag and the winning index.
- The arbiter instantiates the picker once, plus the FSM and the optional timeout counter.

## Test plan

- **Reset then contention:** all 4 requesters present 1-byte packets 0xA0..0xA3 at once.
  - FIFO receives A0, A1, A2, A3 in that order.
  - Each write is separated by one idle cycle; `grant_id` steps 0→1→2→3.
- **Packet lock:** req1 sends 3-byte packet 0x11,0x12,0x13(last) while req0 sends 0x01 continuously from cycle 0.
  - Assuming req1 holds the grant first, its 3 bytes are written contiguously.
  - 0x01 is written only after 0x13.
- **Back-pressure:** `fifo_full` is high for 5 cycles mid-packet.
  - `fifo_wr_en` and `req_ready` stay 0 for those 5 cycles.
  - The byte is written once, on the first cycle after `fifo_full` falls.
- **Reset mid-packet:** `Areset` asserts after the 2nd byte of a 4-byte packet.
  - The next cycle shows `busy`=0 and `grant_id`=0, with no further writes.
  - After release, req0 wins first.
- **Timeout (macro defined, `TIMEOUT`=10):** owner stops `req_valid` mid-packet while req2 waits.
  - `timeout_pulse` is high exactly one cycle, 10 cycles after the last accepted byte.
  - req2 is granted the following cycle.
  - With the macro undefined, the lock persists for 1000 cycles.
